qtable_maxq: RTL and testbench



---
 rtl/qtable_maxq_if.sv | 45 ++++
 rtl/qtable_maxq.sv | 170 +++++++++++++++++
 tb/tb_qtable_maxq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qtable_maxq_if.sv
// Bus bundle for qtable_maxq: write port, point-read port, scan port and init status.
interface qtable_maxq_if #(
  parameter int STATE_WIDTH  = 6,
  parameter int ACTION_WIDTH = 2,
  parameter int DATA_WIDTH   = 8
);
  logic                    o_init_done;

  logic                    i_wr_en;
  logic [STATE_WIDTH-1:0]  i_wr_state;
  logic [ACTION_WIDTH-1:0] i_wr_action;
  logic [DATA_WIDTH-1:0]   i_wr_data;

  logic                    i_rd_en;
  logic [STATE_WIDTH-1:0]  i_rd_state;
  logic [ACTION_WIDTH-1:0] i_rd_action;
  logic                    o_rd_ready;
  logic                    o_rd_valid;
  logic [DATA_WIDTH-1:0]   o_rd_data;

  logic                    i_scan_req;
  logic [STATE_WIDTH-1:0]  i_scan_state;
  logic                    o_scan_ready;
  logic                    o_scan_valid;
  logic [DATA_WIDTH-1:0]   o_scan_max;
  logic [ACTION_WIDTH-1:0] o_scan_action;

  modport master (
    input  o_init_done,
    output i_wr_en, i_wr_state, i_wr_action, i_wr_data,
    output i_rd_en, i_rd_state, i_rd_action,
    input  o_rd_ready, o_rd_valid, o_rd_data,
    output i_scan_req, i_scan_state,
    input  o_scan_ready, o_scan_valid, o_scan_max, o_scan_action
  );

  modport slave (
    output o_init_done,
    input  i_wr_en, i_wr_state, i_wr_action, i_wr_data,
    input  i_rd_en, i_rd_state, i_rd_action,
    output o_rd_ready, o_rd_valid, o_rd_data,
    input  i_scan_req, i_scan_state,
    output o_scan_ready, o_scan_valid, o_scan_max, o_scan_action
  );
endinterface

// File: rtl/qtable_maxq.sv
// Q-value table in inferred block RAM with self-clear after reset, point reads,
// writes, and a per-state max-Q / argmax scan sharing the single read port.
module qtable_maxq #(
  parameter int STATE_WIDTH  = 6,
  parameter int ACTION_WIDTH = 2,
  parameter int DATA_WIDTH   = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  qtable_maxq_if.slave bus
);
  localparam int ADDR_WIDTH = STATE_WIDTH + ACTION_WIDTH;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  // Scan counter value at which the last action's data is being compared.
  localparam logic [ACTION_WIDTH:0] SCAN_LAST = {1'b1, {ACTION_WIDTH{1'b0}}};

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [ACTION_WIDTH:0]   scan_cnt;
  logic [STATE_WIDTH-1:0]  scan_st;
  logic                    init_done_q;

  logic                    scan_ready, rd_ready;
  logic                    rd_accept, scan_accept, init_last, scan_done;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_wa, mem_ra;
  logic [DATA_WIDTH-1:0]   mem_wd, mem_q, byp_data, rdata;
  logic                    byp_hit;

  logic [DATA_WIDTH-1:0]   run_max, next_max;
  logic [ACTION_WIDTH-1:0] run_act, next_act, cmp_act;
  logic                    cmp_take;

  logic                    rd_valid_q, scan_valid_q;
  logic [DATA_WIDTH-1:0]   rd_hold, scan_max_q;
  logic [ACTION_WIDTH-1:0] scan_act_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next-state, handshake readies and accept strobes; scan wins over a coincident point read.
  always_comb begin
    state_d     = state_q;
    scan_ready  = 1'b0;
    rd_ready    = 1'b0;
    rd_accept   = 1'b0;
    scan_accept = 1'b0;
    init_last   = 1'b0;
    scan_done   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (clr_cnt == '1) begin
          init_last = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        scan_ready = 1'b1;
        rd_ready   = !bus.i_scan_req;
        if (bus.i_scan_req) begin
          scan_accept = 1'b1;
          state_d     = ST_SCAN;
        end else if (bus.i_rd_en) begin
          rd_accept = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Memory port steering: clearing owns the write port during init; scan owns the read port in SCAN.
  always_comb begin
    mem_we = (state_q == ST_INIT) || (bus.i_wr_en && init_done_q);
    mem_wa = (state_q == ST_INIT) ? clr_cnt : {bus.i_wr_state, bus.i_wr_action};
    mem_wd = (state_q == ST_INIT) ? '0 : bus.i_wr_data;
    mem_ra = (state_q == ST_SCAN) ? {scan_st, scan_cnt[ACTION_WIDTH-1:0]}
                                  : {bus.i_rd_state, bus.i_rd_action};
  end

  // Block RAM: one write port, one registered read port; same-address collisions are
  // flagged so the read side can substitute the written value (write-first).
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    mem_q    <= mem[mem_ra];
    byp_hit  <= mem_we && (mem_wa == mem_ra);
    byp_data <= mem_wd;
  end

  // Read data with write-first bypass, then the signed running-max compare.
  always_comb begin
    rdata    = byp_hit ? byp_data : mem_q;
    cmp_act  = scan_cnt[ACTION_WIDTH-1:0] - ACTION_WIDTH'(1);
    cmp_take = (scan_cnt == (ACTION_WIDTH+1)'(1)) || ($signed(rdata) > $signed(run_max));
    next_max = cmp_take ? rdata : run_max;
    next_act = cmp_take ? cmp_act : run_act;
  end

  // Clear counter and sticky init-done flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_cnt     <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == ST_INIT) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      if (init_last) init_done_q <= 1'b1;
    end
  end

  // Scan sequencing: count 0 issues action 0, data for action (count-1) is compared each later cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scan_cnt     <= '0;
      scan_st      <= '0;
      run_max      <= '0;
      run_act      <= '0;
      scan_valid_q <= 1'b0;
      scan_max_q   <= '0;
      scan_act_q   <= '0;
    end else begin
      scan_valid_q <= scan_done;
      if (scan_accept) begin
        scan_st  <= bus.i_scan_state;
        scan_cnt <= '0;
      end else if (state_q == ST_SCAN) begin
        scan_cnt <= scan_cnt + (ACTION_WIDTH+1)'(1);
        if (scan_cnt != '0) begin
          run_max <= next_max;
          run_act <= next_act;
        end
        if (scan_done) begin
          scan_max_q <= next_max;
          scan_act_q <= next_act;
        end
      end
    end
  end

  // Point-read valid pulse and holding register for the last returned value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_hold    <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_valid_q) rd_hold <= rdata;
    end
  end

  assign bus.o_init_done   = init_done_q;
  assign bus.o_rd_ready    = rd_ready;
  assign bus.o_rd_valid    = rd_valid_q;
  assign bus.o_rd_data     = rd_valid_q ? rdata : rd_hold;
  assign bus.o_scan_ready  = scan_ready;
  assign bus.o_scan_valid  = scan_valid_q;
  assign bus.o_scan_max    = scan_max_q;
  assign bus.o_scan_action = scan_act_q;
endmodule

// File: tb/tb_qtable_maxq.sv
// Self-checking bench for qtable_maxq: vector tables plus scoreboard queues
// drained by a negedge monitor, and hand-written multi-cycle corner sequences.
module tb_qtable_maxq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qtable_maxq_if #(.STATE_WIDTH(6), .ACTION_WIDTH(2), .DATA_WIDTH(8)) bus ();

  qtable_maxq #(.STATE_WIDTH(6), .ACTION_WIDTH(2), .DATA_WIDTH(8)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [7:0] mx;
    logic [1:0] act;
  } scan_exp_t;

  typedef struct {
    logic [5:0] st;
    logic [1:0] act;
    logic [7:0] wdata;
    logic [7:0] exp;
  } pt_vec_t;

  typedef struct {
    logic [5:0]  st;
    logic [31:0] q;   // {a3, a2, a1, a0}
    logic [7:0]  mx;
    logic [1:0]  act;
  } sc_vec_t;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd_q[$];
  scan_exp_t  scan_q[$];
  pt_vec_t    pt[6];
  sc_vec_t    sc[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_init_done",   32'(bus.o_init_done),   0);
    chk("rst_rd_ready",    32'(bus.o_rd_ready),    0);
    chk("rst_rd_valid",    32'(bus.o_rd_valid),    0);
    chk("rst_rd_data",     32'(bus.o_rd_data),     0);
    chk("rst_scan_ready",  32'(bus.o_scan_ready),  0);
    chk("rst_scan_valid",  32'(bus.o_scan_valid),  0);
    chk("rst_scan_max",    32'(bus.o_scan_max),    0);
    chk("rst_scan_action", 32'(bus.o_scan_action), 0);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_rd_valid === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got valid with data %0h, required no read", bus.o_rd_data);
        end else begin
          logic [7:0] e;
          e = rd_q.pop_front();
          checks--;
          chk("rd_data", 32'(bus.o_rd_data), 32'(e));
        end
      end
      if (bus.o_scan_valid === 1'b1) begin
        checks++;
        if (scan_q.size() == 0) begin
          errors++;
          $display("FAIL scan_unexpected: got max %0h action %0d, required no result",
                   bus.o_scan_max, bus.o_scan_action);
        end else begin
          scan_exp_t s;
          s = scan_q.pop_front();
          checks--;
          chk("scan_max", 32'(bus.o_scan_max), 32'(s.mx));
          chk("scan_action", 32'(bus.o_scan_action), 32'(s.act));
        end
      end
    end
  end

  task automatic do_write(input logic [5:0] s, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.i_wr_en = 1'b1; bus.i_wr_state = s; bus.i_wr_action = a; bus.i_wr_data = d;
    @(posedge clk); #1;
    bus.i_wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] s, input logic [1:0] a, input logic [7:0] exp);
    @(negedge clk);
    bus.i_rd_en = 1'b1; bus.i_rd_state = s; bus.i_rd_action = a;
    #1;
    chk("rd_ready_idle", 32'(bus.o_rd_ready), 1);
    rd_q.push_back(exp);
    @(posedge clk); #1;
    bus.i_rd_en = 1'b0;
  endtask

  task automatic start_scan(input logic [5:0] s, input logic push,
                            input logic [7:0] mx, input logic [1:0] act);
    @(negedge clk);
    bus.i_scan_req = 1'b1; bus.i_scan_state = s;
    #1;
    chk("scan_ready_idle", 32'(bus.o_scan_ready), 1);
    if (push) scan_q.push_back('{mx: mx, act: act});
    @(posedge clk); #1;
    bus.i_scan_req = 1'b0;
  endtask

  // Counts edges after the accept edge until o_scan_valid is seen (bounded).
  task automatic wait_scan(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.o_scan_valid) break;
    end
  endtask

  // Counts edges after reset release until o_init_done; pokes issued at release are dropped after 4 cycles.
  task automatic wait_init(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      n++;
      if (n == 4) begin
        bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0; bus.i_scan_req = 1'b0;
      end
      if (bus.o_init_done) break;
    end
  endtask

  initial begin
    int n;
    pt[0] = '{st: 6'd0,  act: 2'd0, wdata: 8'h7F, exp: 8'h7F};
    pt[1] = '{st: 6'd63, act: 2'd3, wdata: 8'h80, exp: 8'h80};
    pt[2] = '{st: 6'd1,  act: 2'd2, wdata: 8'hFF, exp: 8'hFF};
    pt[3] = '{st: 6'd17, act: 2'd1, wdata: 8'h01, exp: 8'h01};
    pt[4] = '{st: 6'd32, act: 2'd0, wdata: 8'hA5, exp: 8'hA5};
    pt[5] = '{st: 6'd2,  act: 2'd3, wdata: 8'h5A, exp: 8'h5A};

    sc[0] = '{st: 6'd5,  q: {8'h07, 8'h07, 8'hFE, 8'h03}, mx: 8'h07, act: 2'd2};
    sc[1] = '{st: 6'd9,  q: {8'h80, 8'hFB, 8'hFF, 8'hF8}, mx: 8'hFF, act: 2'd1};
    sc[2] = '{st: 6'd20, q: {8'h80, 8'h80, 8'h80, 8'h80}, mx: 8'h80, act: 2'd0};
    sc[3] = '{st: 6'd33, q: {8'h00, 8'h00, 8'h7F, 8'h7F}, mx: 8'h7F, act: 2'd0};
    sc[4] = '{st: 6'd40, q: {8'h02, 8'h9C, 8'h03, 8'hFB}, mx: 8'h03, act: 2'd1};
    sc[5] = '{st: 6'd41, q: {8'h01, 8'h00, 8'h00, 8'h00}, mx: 8'h01, act: 2'd3};
    sc[6] = '{st: 6'd63, q: {8'hFC, 8'hFD, 8'hFE, 8'hFF}, mx: 8'hFF, act: 2'd0};

    bus.i_wr_en = 1'b0; bus.i_wr_state = '0; bus.i_wr_action = '0; bus.i_wr_data = '0;
    bus.i_rd_en = 1'b0; bus.i_rd_state = '0; bus.i_rd_action = '0;
    bus.i_scan_req = 1'b0; bus.i_scan_state = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();

    // Release reset with a write, read and scan already pending; all must be ignored during init.
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_wr_state = 6'd1; bus.i_wr_action = 2'd1; bus.i_wr_data = 8'h11;
    bus.i_rd_en = 1'b1; bus.i_rd_state = 6'd1; bus.i_rd_action = 2'd1;
    #1;
    chk("init_rd_ready", 32'(bus.o_rd_ready), 0);
    chk("init_scan_ready", 32'(bus.o_scan_ready), 0);
    bus.i_scan_req = 1'b1;
    wait_init(n);
    chk("init_latency", 32'(n), 256);
    do_read(6'd1, 2'd1, 8'h00);
    do_read(6'd63, 2'd3, 8'h00);

    // Point write/read table: all writes first so address aliasing shows up on readback.
    foreach (pt[i]) do_write(pt[i].st, pt[i].act, pt[i].wdata);
    foreach (pt[i]) do_read(pt[i].st, pt[i].act, pt[i].exp);
    repeat (2) @(posedge clk);
    #1;
    chk("rd_hold_data", 32'(bus.o_rd_data), 32'(pt[5].exp));
    chk("rd_valid_pulse", 32'(bus.o_rd_valid), 0);

    // Scan table.
    foreach (sc[i]) begin
      for (int a = 0; a < 4; a++) do_write(sc[i].st, 2'(a), sc[i].q[8*a +: 8]);
      start_scan(sc[i].st, 1'b1, sc[i].mx, sc[i].act);
      wait_scan(n);
      chk("scan_latency", 32'(n), 5);
    end

    // Back-to-back: new scan requested in the result cycle of the previous one.
    start_scan(6'd9, 1'b1, 8'hFF, 2'd1);
    wait_scan(n);
    bus.i_scan_req = 1'b1; bus.i_scan_state = 6'd5;
    #1;
    chk("b2b_scan_ready", 32'(bus.o_scan_ready), 1);
    scan_q.push_back('{mx: 8'h07, act: 2'd2});
    @(posedge clk); #1;
    bus.i_scan_req = 1'b0;
    wait_scan(n);
    chk("b2b_latency", 32'(n), 5);

    // Scan and point read coincide: scan wins, read is refused.
    @(negedge clk);
    bus.i_scan_req = 1'b1; bus.i_scan_state = 6'd33;
    bus.i_rd_en = 1'b1; bus.i_rd_state = 6'd0; bus.i_rd_action = 2'd0;
    #1;
    chk("coincide_rd_ready", 32'(bus.o_rd_ready), 0);
    chk("coincide_scan_ready", 32'(bus.o_scan_ready), 1);
    scan_q.push_back('{mx: 8'h7F, act: 2'd0});
    @(posedge clk); #1;
    bus.i_scan_req = 1'b0; bus.i_rd_en = 1'b0;
    wait_scan(n);

    // Write and point read of the same address in one cycle return the new value.
    @(negedge clk);
    bus.i_wr_en = 1'b1; bus.i_wr_state = 6'd12; bus.i_wr_action = 2'd1; bus.i_wr_data = 8'h2A;
    bus.i_rd_en = 1'b1; bus.i_rd_state = 6'd12; bus.i_rd_action = 2'd1;
    rd_q.push_back(8'h2A);
    @(posedge clk); #1;
    bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0;

    // Writes during a scan of state 5: action 0 after it was read, action 3 on its read edge.
    start_scan(6'd5, 1'b1, 8'h50, 2'd3);
    @(posedge clk); #1;                       // edge k+1: action 0 read
    bus.i_wr_en = 1'b1; bus.i_wr_state = 6'd5; bus.i_wr_action = 2'd0; bus.i_wr_data = 8'h60;
    bus.i_rd_en = 1'b1; bus.i_rd_state = 6'd5; bus.i_rd_action = 2'd1;
    #1;
    chk("scan_rd_ready", 32'(bus.o_rd_ready), 0);
    chk("scan_scan_ready", 32'(bus.o_scan_ready), 0);
    @(posedge clk); #1;                       // edge k+2
    bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0;
    @(posedge clk); #1;                       // edge k+3
    bus.i_wr_en = 1'b1; bus.i_wr_state = 6'd5; bus.i_wr_action = 2'd3; bus.i_wr_data = 8'h50;
    @(posedge clk); #1;                       // edge k+4: action 3 read
    bus.i_wr_en = 1'b0;
    n = 4;
    for (int i = 0; i < 16; i++) begin
      if (bus.o_scan_valid) break;
      @(posedge clk); #1;
      n++;
    end
    chk("midscan_latency", 32'(n), 5);
    do_read(6'd5, 2'd0, 8'h60);
    do_read(6'd5, 2'd3, 8'h50);

    // Reset two cycles into a scan: aborted, outputs cleared at once, table cleared again.
    do_write(6'd30, 2'd2, 8'h33);
    start_scan(6'd30, 1'b0, 8'h00, 2'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    chk("reinit_latency", 32'(n), 256);
    do_read(6'd30, 2'd2, 8'h00);
    do_read(6'd12, 2'd1, 8'h00);
    do_read(6'd5, 2'd3, 8'h00);

    repeat (4) @(posedge clk);
    #1;
    chk("rd_queue_drained", 32'(rd_q.size()), 0);
    chk("scan_queue_drained", 32'(scan_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
